accu_grp: RTL and testbench
===========================

// Module: accu_grp
// PURPOSE
//  Parametrised group accumulator: sums every GROUP_N accepted input samples and emits one
//  registered sum per group. Supports downstream backpressure and an early flush that emits
//  a partial-group sum. Sits between a sample source and a downstream consumer; both sides
//  use valid/ready handshakes.
// PARAMETERS
//  DATA_W   8                         input sample width, unsigned
//  GROUP_N  4                         samples per group, >= 1
//  OUT_W    DATA_W+$clog2(GROUP_N)    sum width; a full group of maximum-value samples never overflows
//  CNT_W    $clog2(GROUP_N+1)         width of the sample-count output
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  data_in    in   DATA_W  input sample
//  valid_in   in   1       data_in is valid
//  ready_a    out  1       block can accept a sample this cycle
//  flush      in   1       close the current group early; qualified like data (see below)
//  ready_b    in   1       downstream can take data_out this cycle
//  valid_out  out  1       data_out and cnt_out are valid
//  data_out   out  OUT_W   group sum
//  cnt_out    out  CNT_W   number of samples in data_out (1..GROUP_N)
// BEHAVIOUR
//  - Reset (async, rst_n=0): valid_out=0, data_out=0, cnt_out=0, acc=0, count=0, ready_a=0.
//    A partial group is discarded.
//  - Handshakes:
//    - ready_a = rst_n & (~valid_out | ready_b): combinational, so the block accepts in the same
//      cycle the held result drains.
//    - Accept event: valid_in & ready_a at a rising clk edge.
//    - Output transfer: valid_out & ready_b at a rising clk edge.
//  - flush is acted on only when ready_a=1; the source holds it until then. flush may coincide
//    with a sample, and that sample is included in the flushed group.
//  - Per edge, with ready_a=1:
//    - Accept with count < GROUP_N-1 and no flush: acc += data_in (acc = data_in when count==0);
//      count += 1.
//    - Group close: accept with count == GROUP_N-1, or flush while (count + accept) > 0.
//      data_out <= acc + (accept ? data_in : 0); cnt_out <= count + accept; valid_out <= 1;
//      acc <= 0; count <= 0.
//    - flush with count==0 and no accept: no-op; valid_out is not asserted.
//    - Otherwise, on an output transfer: valid_out <= 0. data_out and cnt_out hold their last values.
//  - While valid_out=1 and ready_b=0: data_out and cnt_out hold stable, ready_a=0, and no state
//    changes.
//  - Latency: valid_out goes high on the same edge that accepts the last sample of the group,
//    i.e. visible 1 cycle after that sample was presented.
//  - Back-to-back: with ready_b=1 held high, one sample is accepted every cycle and one sum is
//    produced every GROUP_N cycles, with no bubble.
//  - GROUP_N=1: every accepted sample is emitted directly, cnt_out=1.
//  - Arithmetic is unsigned with zero-extension to OUT_W. No saturation is needed by construction.
//  - States:
//    - EMPTY (count=0, valid_out=0)
//    - ACC (count>0, valid_out=0)
//    - HOLD (valid_out=1, count may also be >0 after a drain-and-accept)
//    Transitions as above. Reset from any state goes to EMPTY.
// TESTING
//  1. GROUP_N=4, ready_b=1, stream 1,2,3,14, 5,2,103,4, 5,6,3,54 on consecutive cycles
//     -> three valid_out pulses: 20, 114, 68, each with cnt_out=4, spaced 4 cycles apart.
//  2. Max values: 255 x4 -> data_out=1020 (10-bit), no wrap.
//  3. Backpressure: ready_b=0 when sum 20 is produced
//     -> valid_out holds 20 and ready_a=0 until ready_b=1; next samples are then accepted
//     with no loss, and the following sum is 114.
//  4. Flush: accept 7,8, then flush together with sample 9 -> data_out=24, cnt_out=3.
//     A following flush with count=0 -> no valid_out.
//  5. Reset mid-group: accept 1,2, pulse rst_n low for 1 cycle, then send 3,4,5,6
//     -> single sum 18; valid_out=0 and ready_a=0 during reset.
//  6. GROUP_N=1, DATA_W=4: stream 15,3 -> valid_out on consecutive cycles with 15 then 3, cnt_out=1.

Source files
------------

// File: rtl/accu_grp.sv
// Group accumulator: sums every GROUP_N accepted samples, or a shorter group on flush, and
// presents each sum through a registered valid/ready output stage.
module accu_grp #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned GROUP_N = 4,
    parameter int unsigned OUT_W   = DATA_W + $clog2(GROUP_N),
    parameter int unsigned CNT_W   = $clog2(GROUP_N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_a,
    input  logic              flush,
    input  logic              ready_b,
    output logic              valid_out,
    output logic [OUT_W-1:0]  data_out,
    output logic [CNT_W-1:0]  cnt_out
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(GROUP_N - 1);

    logic [OUT_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;

    logic             accept;
    logic             close;
    logic [OUT_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;

    // acc_q is always zero whenever count_q is zero, so the first sample needs no special case.
    always_comb begin
        ready_a  = rst_n & (~valid_out | ready_b);
        accept   = valid_in & ready_a;
        sum      = acc_q + (accept ? OUT_W'(data_in) : '0);
        cnt_next = count_q + CNT_W'(accept);
        close    = (accept & (count_q == LastIdx)) | (flush & ready_a & (cnt_next != '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            count_q   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            cnt_out   <= '0;
        end else if (close) begin
            // A close wins over a simultaneous drain: the new sum replaces the old one.
            data_out  <= sum;
            cnt_out   <= cnt_next;
            valid_out <= 1'b1;
            acc_q     <= '0;
            count_q   <= '0;
        end else begin
            if (accept) begin
                acc_q   <= sum;
                count_q <= cnt_next;
            end
            if (valid_out && ready_b) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accu_grp.sv
// Bench for accu_grp: directed scenarios plus a randomized run against a queue-based model.
module tb_accu_grp;

    logic       clk;
    logic       rst_n;

    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_a;
    logic       flush;
    logic       ready_b;
    logic       valid_out;
    logic [9:0] data_out;
    logic [2:0] cnt_out;

    logic [3:0] d1_data_in;
    logic       d1_valid_in;
    logic       d1_ready_a;
    logic       d1_flush;
    logic       d1_ready_b;
    logic       d1_valid_out;
    logic [3:0] d1_data_out;
    logic [0:0] d1_cnt_out;

    int n_pass;
    int n_total;

    accu_grp #(
        .DATA_W (8),
        .GROUP_N(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_a  (ready_a),
        .flush    (flush),
        .ready_b  (ready_b),
        .valid_out(valid_out),
        .data_out (data_out),
        .cnt_out  (cnt_out)
    );

    accu_grp #(
        .DATA_W (4),
        .GROUP_N(1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (d1_data_in),
        .valid_in (d1_valid_in),
        .ready_a  (d1_ready_a),
        .flush    (d1_flush),
        .ready_b  (d1_ready_b),
        .valid_out(d1_valid_out),
        .data_out (d1_data_out),
        .cnt_out  (d1_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic rb);
        valid_in = v;
        data_in  = d;
        flush    = f;
        ready_b  = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        d1_valid_in = 1'b0;
        d1_data_in  = 4'd0;
        d1_flush    = 1'b0;
        d1_ready_b  = 1'b1;
        #1;
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out);
        else n_pass++;
        n_total++;
        if (ready_a !== 1'b0) $display("FAIL reset_ready_a: got %b want 0", ready_a);
        else n_pass++;
        n_total++;
        if (data_out !== 10'd0) $display("FAIL reset_data: got %0d want 0", data_out);
        else n_pass++;
        n_total++;
        if (cnt_out !== 3'd0) $display("FAIL reset_cnt: got %0d want 0", cnt_out);
        else n_pass++;
        n_total++;
        if (d1_valid_out !== 1'b0 || d1_ready_a !== 1'b0)
            $display("FAIL reset_g1: got valid=%b ready=%b want 0 0", d1_valid_out, d1_ready_a);
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (ready_a !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ready_a);
        else n_pass++;
    endtask

    task automatic test_stream();
        int unsigned smp [12] = '{1, 2, 3, 14, 5, 2, 103, 4, 5, 6, 3, 54};
        int unsigned sums [3] = '{20, 114, 68};
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(smp[i]), 1'b0, 1'b1);
            #1;
            n_total++;
            if (ready_a !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, ready_a);
            else n_pass++;
            tick();
            n_total++;
            if (i % 4 == 3) begin
                if (valid_out !== 1'b1 || data_out !== 10'(sums[i/4]) || cnt_out !== 3'd4)
                    $display("FAIL stream_sum[%0d]: got v=%b d=%0d c=%0d want v=1 d=%0d c=4",
                             i / 4, valid_out, data_out, cnt_out, sums[i/4]);
                else n_pass++;
            end else begin
                if (valid_out !== 1'b0)
                    $display("FAIL stream_idle[%0d]: got valid %b want 0", i, valid_out);
                else n_pass++;
            end
        end
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL stream_drain: got valid %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_max();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd255, 1'b0, 1'b1);
            tick();
        end
        n_total++;
        if (valid_out !== 1'b1 || data_out !== 10'd1020 || cnt_out !== 3'd4)
            $display("FAIL max_sum: got v=%b d=%0d c=%0d want v=1 d=1020 c=4",
                     valid_out, data_out, cnt_out);
        else n_pass++;
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        int unsigned smp [8] = '{1, 2, 3, 14, 5, 2, 103, 4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(smp[i]), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'(smp[4]), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (valid_out !== 1'b1 || data_out !== 10'd20 || cnt_out !== 3'd4 || ready_a !== 1'b0)
                $display("FAIL bp_hold[%0d]: got v=%b d=%0d c=%0d rdy=%b want v=1 d=20 c=4 rdy=0",
                         k, valid_out, data_out, cnt_out, ready_a);
            else n_pass++;
            tick();
        end
        for (int i = 4; i < 8; i++) begin
            drive(1'b1, 8'(smp[i]), 1'b0, 1'b1);
            #1;
            n_total++;
            if (ready_a !== 1'b1) $display("FAIL bp_resume_ready[%0d]: got %b want 1", i, ready_a);
            else n_pass++;
            tick();
        end
        n_total++;
        if (valid_out !== 1'b1 || data_out !== 10'd114 || cnt_out !== 3'd4)
            $display("FAIL bp_next_sum: got v=%b d=%0d c=%0d want v=1 d=114 c=4",
                     valid_out, data_out, cnt_out);
        else n_pass++;
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 8'd7, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'd8, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'd9, 1'b1, 1'b1);
        tick();
        n_total++;
        if (valid_out !== 1'b1 || data_out !== 10'd24 || cnt_out !== 3'd3)
            $display("FAIL flush_partial: got v=%b d=%0d c=%0d want v=1 d=24 c=3",
                     valid_out, data_out, cnt_out);
        else n_pass++;
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_total++;
            if (valid_out !== 1'b0)
                $display("FAIL flush_empty[%0d]: got valid %b want 0", k, valid_out);
            else n_pass++;
        end
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid();
        int unsigned smp [4] = '{3, 4, 5, 6};
        drive(1'b1, 8'd1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'd2, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (valid_out !== 1'b0 || ready_a !== 1'b0 || data_out !== 10'd0 || cnt_out !== 3'd0)
            $display("FAIL rstmid_during: got v=%b rdy=%b d=%0d c=%0d want 0 0 0 0",
                     valid_out, ready_a, data_out, cnt_out);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(smp[i]), 1'b0, 1'b1);
            tick();
            n_total++;
            if (i < 3) begin
                if (valid_out !== 1'b0)
                    $display("FAIL rstmid_idle[%0d]: got valid %b want 0", i, valid_out);
                else n_pass++;
            end else begin
                if (valid_out !== 1'b1 || data_out !== 10'd18 || cnt_out !== 3'd4)
                    $display("FAIL rstmid_sum: got v=%b d=%0d c=%0d want v=1 d=18 c=4",
                             valid_out, data_out, cnt_out);
                else n_pass++;
            end
        end
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_group1();
        int unsigned smp [2] = '{15, 3};
        for (int i = 0; i < 2; i++) begin
            d1_valid_in = 1'b1;
            d1_data_in  = 4'(smp[i]);
            d1_ready_b  = 1'b1;
            #1;
            n_total++;
            if (d1_ready_a !== 1'b1) $display("FAIL g1_ready[%0d]: got %b want 1", i, d1_ready_a);
            else n_pass++;
            tick();
            n_total++;
            if (d1_valid_out !== 1'b1 || d1_data_out !== 4'(smp[i]) || d1_cnt_out !== 1'b1)
                $display("FAIL g1_out[%0d]: got v=%b d=%0d c=%0d want v=1 d=%0d c=1",
                         i, d1_valid_out, d1_data_out, d1_cnt_out, smp[i]);
            else n_pass++;
        end
        d1_valid_in = 1'b0;
        tick();
        n_total++;
        if (d1_valid_out !== 1'b0) $display("FAIL g1_drain: got valid %b want 0", d1_valid_out);
        else n_pass++;
    endtask

    // Model: a queue holds the open group; a held flag with sum/count mirrors the output stage.
    task automatic test_random();
        int unsigned cur [$];
        bit          m_held;
        int unsigned m_sum;
        int unsigned m_cnt;
        bit          m_ready;
        bit          v;
        bit          f;
        bit          rb;
        logic [7:0]  d;
        int unsigned s;

        drive(1'b0, 8'd0, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        m_held = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            v  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 7) == 0);
            rb = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            drive(v, d, f, rb);
            #1;
            m_ready = !m_held || rb;
            n_total++;
            if (ready_a !== m_ready)
                $display("FAIL rand_ready[%0d]: got %b want %b", cyc, ready_a, m_ready);
            else n_pass++;
            @(posedge clk);
            if (m_ready) begin
                if (v) cur.push_back(int'(d));
                if (cur.size() == 4 || (f && cur.size() > 0)) begin
                    s = 0;
                    foreach (cur[k]) s += cur[k];
                    m_held = 1'b1;
                    m_sum  = s;
                    m_cnt  = cur.size();
                    cur.delete();
                end else if (m_held && rb) begin
                    m_held = 1'b0;
                end
            end
            #1;
            n_total++;
            if (valid_out !== m_held || data_out !== 10'(m_sum) || cnt_out !== 3'(m_cnt))
                $display("FAIL rand_out[%0d]: got v=%b d=%0d c=%0d want v=%b d=%0d c=%0d",
                         cyc, valid_out, data_out, cnt_out, m_held, m_sum, m_cnt);
            else n_pass++;
        end
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_stream();
        test_max();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_group1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
